fft64_inbuf_ctrl: RTL and testbench
===================================

# fft64_inbuf_ctrl

Address/control sequencer for the 2x64 complex ping-pong buffer that reorders data between FFT64 stages. It accepts a continuous complex sample stream framed by START and registers each sample. It issues buffer write addresses, write enable, the half-select ODD, and read addresses in bit-reversed or natural order. It also flags when reordered data emerges from the buffer, for the downstream butterfly stage.

## Interface
- nb, 16, data width of real and imaginary parts
- RD_LAT, 2, buffer read latency in ED cycles from ADDRR to data out
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- ED  in  1  global enable; all state advances only when ED=1
- START  in  1  stream start/resync pulse; sample 0 arrives on the next ED cycle
- DR, DI  in  nb  input sample, real/imag
- WE  out  1  buffer write enable
- ODD  out  1  buffer half select; write half = ~ODD, read half = ODD
- ADDRW  out  6  buffer write address
- ADDRR  out  6  buffer read address
- DRW, DIW  out  nb  registered sample to buffer DR/DI
- RDY  out  1  one-ED-cycle pulse aligned with the first reordered sample of each block at buffer output
- VLD  out  1  high while buffer output carries valid reordered data

## Operation
- States:
  - IDLE: no writes, no reads.
  - FILL: first block is written; no reads.
  - RUN: writes and reads run concurrently.
- IDLE -> FILL on START. FILL -> RUN when write counter wraps 63->0. RUN stays RUN until reset.
- START in FILL or RUN is a resync:
  - write counter cleared; state -> FILL.
  - read side stops immediately; VLD drops; pending RDY is cancelled.
  - ODD is not changed.
- Write side:
  - 6-bit counter wcnt increments once per ED cycle while in FILL/RUN.
  - ADDRW = wcnt.
  - DRW/DIW = DR/DI delayed one ED cycle.
  - WE = 1 for every sample in FILL/RUN.
- ODD toggles at the edge where ADDRW goes 63 -> 0, i.e. each block boundary.
- Read side:
  - 6-bit counter rcnt starts at 0 on entry to RUN and increments each ED cycle.
  - ADDRR = reorder(rcnt).
  - Reads one block behind writes, from the half just completed.
- VLD/RDY: the read-issue flag and the block-start flag are delayed RD_LAT ED cycles through a shift register. They become VLD and RDY.
- ED=0: every register holds, including the delay line. Outputs keep their values.

## Timing
- START sampled at ED cycle t0. Sample x_n is on DR/DI at t0+1+n.
- Write of x_n: WE=1, ADDRW=n mod 64, DRW=x_n at t0+2+n (1-cycle input register).
- ODD: 0 at t0+2..t0+65, then 1 from t0+66, then toggles every 64 ED cycles.
- First read: ADDRR=reorder(0) at t0+66, coincident with ADDRW=0 of block 1.
- First RDY=1 at t0+66+RD_LAT. VLD rises at the same cycle and stays high in steady RUN.
- RDY is then repeated every 64 ED cycles.
- Reset (async, RST_N=0):
  - state IDLE; wcnt=rcnt=0; delay line cleared.
  - WE=0, ODD=0, ADDRW=0, ADDRR=0, DRW=DIW=0, RDY=0, VLD=0.
- Reset mid-stream aborts immediately. No further WE until the next START after release.
- START coincident with the wrap edge: resync wins. wcnt=0, state FILL, ODD still toggles from the wrap.
- ADDRW and ADDRR are never equal in the same half, because the read half is always the opposite of the write half.

## Configuration
- FFT64_BITREV_EN defined: reorder(r) = 6-bit bit-reverse of r (r[0..5] -> r[5..0]). This is the FFT input/output reordering.
- FFT64_BITREV_EN undefined: reorder(r) = r. The block then acts as a pure 64-sample ping-pong delay; all timing is identical.

## Test plan
- Reset: hold RST_N=0 with START/ED toggling -> all outputs 0, no WE; release -> remain IDLE until START.
- Single stream, ED=1, x_n=n, bitrev on:
  - t0+66: ADDRR=0. t0+67: ADDRR=32. t0+68: ADDRR=16.
  - RDY at t0+68 (RD_LAT=2).
  - Buffer model output sequence 0,32,16,48,8,...
- Same stream, macro off -> buffer output 0,1,2,...,63, with RDY at t0+68 and every 64 cycles thereafter.
- ED gating: ED=0 for 5 cycles at write index 30 -> ADDRW/ODD/ADDRR frozen, then resume at 31; block boundaries shift by exactly 5 cycles.
- Resync: START at write index 40 in RUN:
  - VLD drops next cycle; ADDRW restarts at 0 after 2 cycles; ODD unchanged.
  - No RDY until 64 new samples have been written.
- Async reset asserted mid-RUN between clock edges -> outputs clear without waiting for CLK; restart with START reproduces the scenario-2 timing.

Source files
------------

// File: rtl/fft64_inbuf_ctrl.sv
// rtl/fft64_inbuf_ctrl.sv - address/control sequencer for the FFT64 2x64 ping-pong reorder buffer
//
// Purpose: registers an input complex stream framed by start, writes it into one
// half of a 2x64 buffer and reads the other half in reordered order,
// one block behind. The read-issue and block-start flags are delayed by the
// buffer read latency so that vld/rdy line up with the data at the buffer output.
//
// Optional feature macro: FFT64_BITREV_EN
//   defined   : read address = 6-bit bit-reverse of the read counter
//   undefined : read address = read counter (plain 64-sample ping-pong delay)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ed         in   global enable; nothing advances while low
//   start      in   stream start / resync pulse; sample 0 follows on the next ed cycle
//   dr, di     in   input sample, real / imaginary
//   we         out  buffer write enable
//   odd        out  half select; write half = ~odd, read half = odd
//   addrw      out  buffer write address
//   addrr      out  buffer read address
//   drw, diw   out  registered sample towards the buffer
//   rdy        out  one-cycle pulse with the first reordered sample of a block
//   vld        out  high while the buffer output carries reordered data
module fft64_inbuf_ctrl #(
  parameter int nb     = 16,
  parameter int rd_lat = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ed,
  input  logic          start,
  input  logic [nb-1:0] dr,
  input  logic [nb-1:0] di,
  output logic          we,
  output logic          odd,
  output logic [5:0]    addrw,
  output logic [5:0]    addrr,
  output logic [nb-1:0] drw,
  output logic [nb-1:0] diw,
  output logic          rdy,
  output logic          vld
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

  state_t          state;
  logic [5:0]      wcnt;
  logic [5:0]      rcnt;
  logic [rd_lat:0] vld_sr;
  logic [rd_lat:0] rdy_sr;
  logic            rd_issue;
  logic            rd_sob;

  function automatic logic [5:0] reorder(input logic [5:0] r);
    logic [5:0] res;
`ifdef FFT64_BITREV_EN
    for (int i = 0; i < 6; i++) res[i] = r[5-i];
`else
    res = r;
`endif
    return res;
  endfunction

  // Stage 0 of the delay line is loaded on the same edge that registers addrr,
  // so the tap at index rd_lat lines up with the buffer output.
  always_comb begin
    rd_issue = (state == ST_RUN);
    rd_sob   = rd_issue && (rcnt == 6'd0);
  end

  assign vld = vld_sr[rd_lat];
  assign rdy = rdy_sr[rd_lat];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      rcnt   <= '0;
      we     <= 1'b0;
      odd    <= 1'b0;
      addrw  <= '0;
      addrr  <= '0;
      drw    <= '0;
      diw    <= '0;
      vld_sr <= '0;
      rdy_sr <= '0;
    end else if (ed) begin
      drw <= dr;
      diw <= di;

      if (state != ST_IDLE) begin
        we    <= 1'b1;
        addrw <= wcnt;
        // Block boundary: addrw steps 63 -> 0. A resync never suppresses this.
        if (we && addrw == 6'd63) odd <= ~odd;
      end else begin
        we <= 1'b0;
      end

      if (start) begin
        // Resync: restart the write block, kill the read side and anything
        // still travelling through the delay line; odd is left alone.
        state  <= ST_FILL;
        wcnt   <= '0;
        rcnt   <= '0;
        vld_sr <= '0;
        rdy_sr <= '0;
      end else begin
        if (state != ST_IDLE) wcnt <= wcnt + 6'd1;
        if (state == ST_FILL && wcnt == 6'd63) begin
          state <= ST_RUN;
          rcnt  <= '0;
        end
        if (state == ST_RUN) begin
          addrr <= reorder(rcnt);
          rcnt  <= rcnt + 6'd1;
        end
        vld_sr <= {vld_sr[rd_lat-1:0], rd_issue};
        rdy_sr <= {rdy_sr[rd_lat-1:0], rd_sob};
      end
    end
  end

endmodule

// File: tb/tb_fft64_inbuf_ctrl.sv
// tb/tb_fft64_inbuf_ctrl.sv - self-checking bench for fft64_inbuf_ctrl
module tb_fft64_inbuf_ctrl;
  localparam int NB     = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ed;
  logic          start;
  logic [NB-1:0] dr, di, drw, diw;
  logic          we, odd, rdy, vld;
  logic [5:0]    addrw, addrr;

  always #5 clk = ~clk;

  fft64_inbuf_ctrl #(.nb(NB), .rd_lat(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ed(ed), .start(start), .dr(dr), .di(di),
    .we(we), .odd(odd), .addrw(addrw), .addrr(addrr), .drw(drw), .diw(diw),
    .rdy(rdy), .vld(vld)
  );

  typedef struct { int now; logic we; int addrw; logic odd; int ridx; logic vld; logic rdy; } vec_t;
  typedef struct { logic [31:0] data; logic rdy; } exp_t;

  vec_t        tbl[12];
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] blk[64];
  logic [31:0] mem[2][64];
  logic [31:0] rp[RD_LAT];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_sent = 0;
  int          n_pop = 0;
  int          stream_id = 0;
  int          since_rdy = 0;
  bit          have_rdy = 1'b0;

  function automatic logic [5:0] ro(input logic [5:0] r);
`ifdef FFT64_BITREV_EN
    return {r[0], r[1], r[2], r[3], r[4], r[5]};
`else
    return r;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Buffer model: write half ~odd, read half odd, RD_LAT cycles of read latency.
  always @(posedge clk) begin
    if (ed) begin
      if (we) mem[!odd][addrw] <= {drw, diw};
      rp[0] <= mem[odd][addrr];
      for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
  end

  // Scoreboard consumer: one buffer output per ed cycle.
  always @(negedge clk) begin
    if (rst_n && ed) begin
      if (sbq.size() == 0) begin
        chk("vld_without_data", 32'(vld), 32'd0);
      end else if (vld) begin
        mon_e = sbq.pop_front();
        n_pop++;
        chk("buf_data", rp[RD_LAT-1], mon_e.data);
        chk("buf_rdy", 32'(rdy), 32'(mon_e.rdy));
      end
      if (!vld) chk("rdy_without_vld", 32'(rdy), 32'd0);
      if (vld && rdy) begin
        if (have_rdy) chk("rdy_period", 32'(since_rdy), 32'd64);
        have_rdy  = 1'b1;
        since_rdy = 0;
      end
      since_rdy++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    sbq.delete();
    have_rdy = 1'b0;
  endtask

  task automatic ed_cycle();
    dr = NB'(n_sent);
    di = NB'(n_sent * 5 + stream_id * 1000);
    ed = 1'b1;
    blk[n_sent % 64] = {dr, di};
    if (n_sent % 64 == 63)
      for (int k = 0; k < 64; k++) sbq.push_back('{blk[ro(6'(k))], k == 0});
    n_sent++;
    step();
  endtask

  task automatic start_stream();
    start = 1'b1;
    ed    = 1'b1;
    dr    = '0;
    di    = '0;
    step();
    start = 1'b0;
    sb_clear();
    n_sent = 0;
    stream_id++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},    32'(we),    32'd0);
    chk({tag, "_odd"},   32'(odd),   32'd0);
    chk({tag, "_addrw"}, 32'(addrw), 32'd0);
    chk({tag, "_addrr"}, 32'(addrr), 32'd0);
    chk({tag, "_drw"},   32'(drw),   32'd0);
    chk({tag, "_diw"},   32'(diw),   32'd0);
    chk({tag, "_rdy"},   32'(rdy),   32'd0);
    chk({tag, "_vld"},   32'(vld),   32'd0);
  endtask

  // After ed_cycle of sample n the observed time is t0+n+2, i.e. now = n_sent+1.
  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      while (n_sent + 1 < tbl[i].now) ed_cycle();
      chk($sformatf("%s_t%0d_we", tag, tbl[i].now),    32'(we),    32'(tbl[i].we));
      chk($sformatf("%s_t%0d_addrw", tag, tbl[i].now), 32'(addrw), 32'(tbl[i].addrw));
      chk($sformatf("%s_t%0d_odd", tag, tbl[i].now),   32'(odd),   32'(tbl[i].odd));
      chk($sformatf("%s_t%0d_addrr", tag, tbl[i].now), 32'(addrr), 32'(ro(6'(tbl[i].ridx))));
      chk($sformatf("%s_t%0d_vld", tag, tbl[i].now),   32'(vld),   32'(tbl[i].vld));
      chk($sformatf("%s_t%0d_rdy", tag, tbl[i].now),   32'(rdy),   32'(tbl[i].rdy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    //            now  we    addrw odd   ridx vld   rdy
    tbl[0]  = '{  1, 1'b0,  0, 1'b0,  0, 1'b0, 1'b0};
    tbl[1]  = '{  2, 1'b1,  0, 1'b0,  0, 1'b0, 1'b0};
    tbl[2]  = '{  3, 1'b1,  1, 1'b0,  0, 1'b0, 1'b0};
    tbl[3]  = '{ 65, 1'b1, 63, 1'b0,  0, 1'b0, 1'b0};
    tbl[4]  = '{ 66, 1'b1,  0, 1'b1,  0, 1'b0, 1'b0};
    tbl[5]  = '{ 67, 1'b1,  1, 1'b1,  1, 1'b0, 1'b0};
    tbl[6]  = '{ 68, 1'b1,  2, 1'b1,  2, 1'b1, 1'b1};
    tbl[7]  = '{ 69, 1'b1,  3, 1'b1,  3, 1'b1, 1'b0};
    tbl[8]  = '{129, 1'b1, 63, 1'b1, 63, 1'b1, 1'b0};
    tbl[9]  = '{130, 1'b1,  0, 1'b0,  0, 1'b1, 1'b0};
    tbl[10] = '{131, 1'b1,  1, 1'b0,  1, 1'b1, 1'b0};
    tbl[11] = '{132, 1'b1,  2, 1'b0,  2, 1'b1, 1'b1};

    // Reset held while start/ed toggle.
    rst_n = 1'b0; ed = 1'b0; start = 1'b0; dr = '0; di = '0;
    for (int i = 0; i < 6; i++) begin
      ed    = 1'($urandom);
      start = 1'($urandom);
      dr    = NB'($urandom);
      di    = NB'($urandom);
      step();
      check_zero("rst_hold");
    end
    rst_n = 1'b1; start = 1'b0; ed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_we", 32'(we), 32'd0);
      chk("idle_vld", 32'(vld), 32'd0);
    end

    // Main stream timing.
    start_stream();
    run_table("run");

    // ed gating at write index 30 of block 3 (now = 224).
    while (n_sent != 3 * 64 + 31) ed_cycle();
    chk("gate_pre_addrw", 32'(addrw), 32'd30);
    ed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dr = NB'($urandom);
      di = NB'($urandom);
      step();
      chk("gate_addrw", 32'(addrw), 32'd30);
      chk("gate_odd",   32'(odd),   32'd1);
      chk("gate_addrr", 32'(addrr), 32'(ro(6'd30)));
    end
    ed_cycle();
    chk("gate_resume_addrw", 32'(addrw), 32'd31);
    chk("gate_resume_addrr", 32'(addrr), 32'(ro(6'd31)));
    while (n_sent != 5 * 64 + 10) ed_cycle();

    // Resync in RUN at write index 40 (block 5, odd = 1).
    while (n_sent % 64 != 41) ed_cycle();
    chk("resync_pre_addrw", 32'(addrw), 32'd40);
    chk("resync_pre_odd", 32'(odd), 32'd1);
    start_stream();
    chk("resync_vld_drop", 32'(vld), 32'd0);
    chk("resync_odd_kept", 32'(odd), 32'd1);
    ed_cycle();
    chk("resync_addrw0", 32'(addrw), 32'd0);
    chk("resync_odd_kept2", 32'(odd), 32'd1);
    while (n_sent + 1 < 67) begin
      ed_cycle();
      chk("resync_vld_low", 32'(vld), 32'd0);
    end
    ed_cycle();
    chk("resync_rdy", 32'(rdy), 32'd1);
    chk("resync_odd_wrap", 32'(odd), 32'd0);
    for (int i = 0; i < 100; i++) ed_cycle();

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("areset");
    sb_clear();
    for (int i = 0; i < 3; i++) begin
      ed    = 1'($urandom);
      start = 1'($urandom);
      step();
    end
    rst_n = 1'b1; start = 1'b0; ed = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("areset_idle_we", 32'(we), 32'd0);
    start_stream();
    run_table("restart");
    for (int i = 0; i < 80; i++) ed_cycle();

    chk("pop_count", 32'(n_pop > 300), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
